mc_ctrl: RTL
============

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port i_clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_inst  input  32  instruction register contents, valid from DECODE onward.
REQ-004 SHALL have port i_mem_ready  input  1  memory accepted/completed the current request.
REQ-005 SHALL have port o_format  output  6  one-hot format to immediate generator: [0]R [1]I [2]S [3]B [4]U [5]J.
REQ-006 SHALL have ports o_mem_req and o_mem_we  output  1 each  memory request and write-enable.
REQ-007 SHALL have ports o_ir_en, o_pc_en and o_rf_we  output  1 each  instruction register, PC and register-file write strobes.
REQ-008 SHALL have port o_state  output  3  current state encoding.
REQ-009 SHALL have port o_trap  output  1  core halted.
REQ-010 SHALL have port o_retired  output  32  count of retired instructions.

Function
REQ-011 SHALL implement Moore FSM states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-012 SHALL decode o_format combinationally from i_inst[6:0] in every state:
- 0110011 -> R.
- 0010011, 0000011, 1100111 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
- All other opcodes -> 6'b000000 (illegal).
REQ-013 FETCH SHALL assert o_mem_req=1 with o_mem_we=0.
- On i_mem_ready=1: assert o_ir_en for that cycle and go to DECODE.
- Otherwise stay in FETCH.
REQ-014 DECODE SHALL go to TRAP when o_format==0; otherwise it SHALL go to EXEC; DECODE is always one cycle.
REQ-015 EXEC SHALL transition as follows:
- Load (0000011) or store (0100011) -> MEM.
- Branch (1100011) -> FETCH, asserting o_pc_en for one cycle.
- All other legal opcodes -> WB.
REQ-016 MEM SHALL assert o_mem_req=1 with o_mem_we=1 for stores and 0 for loads, and hold both stable until i_mem_ready=1.
- Load completion -> WB.
- Store completion -> FETCH, asserting o_pc_en that cycle.
REQ-017 WB SHALL assert o_rf_we=1 and o_pc_en=1 for exactly one cycle, then go to FETCH.
REQ-018 o_retired SHALL increment by 1 on every cycle where o_pc_en=1, and SHALL wrap 0xFFFFFFFF -> 0 with no flag.
REQ-019 TRAP SHALL be absorbing until reset, with o_trap=1 and all strobes and o_mem_req at 0; o_retired SHALL hold.
REQ-020 i_mem_ready SHALL be ignored outside FETCH and MEM.
REQ-021 Once o_mem_req=1 rises, it SHALL NOT deassert before i_mem_ready is sampled high.
REQ-022 i_mem_ready=1 in the first FETCH or MEM cycle SHALL complete with zero wait cycles.
REQ-023 At most one of o_ir_en, o_rf_we SHALL be high in any cycle; o_pc_en SHALL be high at most once per instruction.

Reset
REQ-024 While i_rst_n=0 the block SHALL hold:
- State = FETCH and o_retired = 0.
- o_mem_req, o_mem_we, o_ir_en, o_pc_en, o_rf_we and o_trap = 0.
REQ-025 Reset assertion SHALL take effect immediately in any state, including mid-request in FETCH or MEM and in TRAP, abandoning any outstanding request.
REQ-026 The first cycle after i_rst_n rises SHALL be FETCH with o_mem_req=1.

Verification
REQ-027 ADDI 0x00500093, ready=1 -> states 0,1,2,4,0; o_format=000010; o_rf_we and o_pc_en one cycle in WB; o_retired=1.
REQ-028 SW 0x00112023, MEM ready delayed 3 cycles -> o_mem_req=1 and o_mem_we=1 for 4 MEM cycles; o_format=000100; no o_rf_we; o_pc_en on the completion cycle.
REQ-029 BEQ 0x00000063 -> states 0,1,2,0; o_format=001000; o_pc_en in EXEC only. LUI 0x123450B7 -> o_format=010000 through WB.
REQ-030 Illegal 0xFFFFFFFF -> DECODE then TRAP; o_trap=1 held 20 cycles despite ready toggling; o_retired unchanged.
REQ-031 i_rst_n pulsed low during MEM of LW 0x00012083 with ready=0 -> outputs immediately zero, o_retired=0, restart in FETCH.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle core control unit: fetch/decode/execute/memory/writeback sequencing,
// instruction format decode for the immediate generator, and a retired-instruction counter.
module mc_ctrl (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_inst,
    input  logic        i_mem_ready,
    output logic [5:0]  o_format,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic        o_ir_en,
    output logic        o_pc_en,
    output logic        o_rf_we,
    output logic [2:0]  o_state,
    output logic        o_trap,
    output logic [31:0] o_retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e     state;
    state_e     state_next;
    logic [6:0] opcode;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       mem_req;
    logic       mem_we;
    logic       ir_en;
    logic       pc_en;
    logic       rf_we;
    logic       trap;
    logic       unused_inst_bits;

    assign opcode           = i_inst[6:0];
    assign unused_inst_bits = ^i_inst[31:7];
    assign is_load          = (opcode == OP_LOAD);
    assign is_store         = (opcode == OP_STORE);
    assign is_branch        = (opcode == OP_BRANCH);

    always_comb begin
        case (opcode)
            OP_R:                      o_format = 6'b000001;
            OP_IMM, OP_LOAD, OP_JALR:  o_format = 6'b000010;
            OP_STORE:                  o_format = 6'b000100;
            OP_BRANCH:                 o_format = 6'b001000;
            OP_LUI, OP_AUIPC:          o_format = 6'b010000;
            OP_JAL:                    o_format = 6'b100000;
            default:                   o_format = 6'b000000;
        endcase
    end

    // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_en      = 1'b0;
        pc_en      = 1'b0;
        rf_we      = 1'b0;
        trap       = 1'b0;
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                if (i_mem_ready) begin
                    ir_en      = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: state_next = (o_format == 6'b000000) ? TRAP : EXEC;
            EXEC: begin
                if (o_format == 6'b000000) begin
                    state_next = TRAP;
                end else if (is_load || is_store) begin
                    state_next = MEM;
                end else if (is_branch) begin
                    pc_en      = 1'b1;
                    state_next = FETCH;
                end else begin
                    state_next = WB;
                end
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = is_store;
                if (i_mem_ready) begin
                    pc_en      = is_store;
                    state_next = is_store ? FETCH : WB;
                end
            end
            WB: begin
                rf_we      = 1'b1;
                pc_en      = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                trap       = 1'b1;
                state_next = TRAP;
            end
            default: begin
                trap       = 1'b1;
                state_next = TRAP;
            end
        endcase
    end

    // Strobes are masked by the reset input itself so they drop the instant reset asserts.
    assign o_mem_req = mem_req & i_rst_n;
    assign o_mem_we  = mem_we  & i_rst_n;
    assign o_ir_en   = ir_en   & i_rst_n;
    assign o_pc_en   = pc_en   & i_rst_n;
    assign o_rf_we   = rf_we   & i_rst_n;
    assign o_trap    = trap    & i_rst_n;
    assign o_state   = state;

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_retired <= 32'd0;
        end else if (pc_en) begin
            o_retired <= o_retired + 32'd1;
        end
    end

endmodule
